// File: rtl/startup_blink_sequencer.sv
// Power-up display self-test: blinks the display code BLINK_COUNT times after reset,
// then idles blank; a start request re-runs the sequence and abort cancels it.
module startup_blink_sequencer #(
  parameter int unsigned HALF_PERIOD = 12500000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       code,
  output logic       busy,
  output logic       done,
  output logic [3:0] blink_idx
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [3:0]       IDX_LAST   = 4'(BLINK_COUNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             code_q, code_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       idx_q, idx_d;

  // State and output registers; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      timer_q <= '0;
      code_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; abort is checked first so it beats start in any active state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    case (state_q)
      ST_ARM: begin
        timer_d = '0;
        if (abort) begin
          state_d = ST_IDLE;
          code_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_ON;
          code_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_ON: begin
        if (abort) begin
          state_d = ST_IDLE;
          timer_d = '0;
          code_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_OFF;
          timer_d = '0;
          code_d  = 1'b0;
          idx_d   = idx_q + 4'd1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_d = ST_IDLE;
          timer_d = '0;
          code_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON;
            code_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = ST_ON;
          code_d  = 1'b1;
          busy_d  = 1'b1;
          idx_d   = 4'd0;
        end else begin
          code_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_ARM;
        timer_d = '0;
        code_d  = 1'b0;
        busy_d  = 1'b0;
        idx_d   = 4'd0;
      end
    endcase
  end

  assign code      = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blink_idx = idx_q;

endmodule

// File: tb/tb_startup_blink_sequencer.sv
// Bench for startup_blink_sequencer: directed scenarios plus random start/abort,
// checked every cycle against a run-position model of the blink sequence.
module tb_startup_blink_sequencer;

  localparam int HP  = 4;
  localparam int BC  = 3;
  localparam int RUN = 2 * HP * BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       code, busy, done;
  logic [3:0] blink_idx;

  int vectors = 0;
  int errors  = 0;

  // Model: 0 = waiting for first edge after reset, 1 = running, 2 = idle.
  int m_state = 0;
  int m_pos   = 0;
  int m_idx   = 0;
  logic m_done = 1'b0;

  startup_blink_sequencer #(.HALF_PERIOD(HP), .BLINK_COUNT(BC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .code(code), .busy(busy), .done(done), .blink_idx(blink_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] expected();
    logic e_code;
    logic e_busy;
    e_busy = (m_state == 1);
    e_code = e_busy && ((m_pos % (2 * HP)) < HP);
    return {e_code, e_busy, m_done, m_idx[3:0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_idx = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic ab);
    m_done = 1'b0;
    case (m_state)
      0: begin
        if (ab) m_state = 2;
        else begin m_state = 1; m_pos = 0; m_idx = 0; end
      end
      1: begin
        if (ab) m_state = 2;
        else begin
          m_pos = m_pos + 1;
          if (m_pos == RUN) begin
            m_state = 2; m_done = 1'b1; m_idx = BC;
          end else begin
            m_idx = m_pos / (2 * HP) + (((m_pos % (2 * HP)) >= HP) ? 1 : 0);
          end
        end
      end
      default: begin
        if (st) begin m_state = 1; m_pos = 0; m_idx = 0; end
      end
    endcase
  endtask

  task automatic tick(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(posedge clk);
    model_step(st, ab);
    #1;
  endtask

  task automatic release_reset(input logic st);
    @(negedge clk);
    start = st;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({code, busy, done, blink_idx} !== 7'd0) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b", {code, busy, done, blink_idx}, 7'd0);
    end
  endtask

  task automatic test_auto_run();
    int busy_n = 0, code_n = 0, done_n = 0;
    logic [3:0] idx_at_done = 4'd0;
    release_reset(1'b0);
    for (int k = 1; k <= RUN + 3; k++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if ({code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL auto_run k=%0d got=%b want=%b", k, {code, busy, done, blink_idx}, expected());
      end
      if (k <= RUN && code !== (((k - 1) % (2 * HP)) < HP)) begin
        errors++;
        $display("FAIL auto_pattern k=%0d got=%b want=%b", k, code, (((k - 1) % (2 * HP)) < HP));
      end
      busy_n += busy; code_n += code;
      if (done) begin done_n++; idx_at_done = blink_idx; end
    end
    vectors++;
    if (busy_n != RUN || code_n != HP * BC || done_n != 1 || idx_at_done !== 4'(BC)) begin
      errors++;
      $display("FAIL auto_totals got busy=%0d code=%0d done=%0d idx=%0d want %0d %0d 1 %0d",
               busy_n, code_n, done_n, idx_at_done, RUN, HP * BC, BC);
    end
  endtask

  task automatic test_start_rerun();
    int done_n = 0;
    tick(1'b1, 1'b0);
    vectors++;
    if (code !== 1'b1 || busy !== 1'b1 || blink_idx !== 4'd0) begin
      errors++;
      $display("FAIL rerun_start got code=%b busy=%b idx=%0d want 1 1 0", code, busy, blink_idx);
    end
    for (int k = 2; k <= RUN + 2; k++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if ({code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL rerun k=%0d got=%b want=%b", k, {code, busy, done, blink_idx}, expected());
      end
      done_n += done;
    end
    vectors++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL rerun_done got=%0d want=1", done_n);
    end
  endtask

  task automatic test_abort();
    int guard = 0;
    tick(1'b1, 1'b0);
    while (m_pos != HP * 2 + 1 && guard < 100) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 100 || code !== 1'b1 || blink_idx !== 4'd1) begin
      errors++;
      $display("FAIL abort_setup got code=%b idx=%0d guard=%0d want 1 1 <100", code, blink_idx, guard);
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (code !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || blink_idx !== 4'd1) begin
      errors++;
      $display("FAIL abort_edge got code=%b busy=%b done=%b idx=%0d want 0 0 0 1",
               code, busy, done, blink_idx);
    end
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if (done !== 1'b0 || {code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL abort_quiet k=%0d got=%b want=%b", k, {code, busy, done, blink_idx}, expected());
      end
    end
  endtask

  task automatic test_start_held();
    logic prev_done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    release_reset(1'b1);
    for (int k = 1; k <= RUN + 6; k++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if ({code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL held k=%0d got=%b want=%b", k, {code, busy, done, blink_idx}, expected());
      end
      if (prev_done && (code !== 1'b1 || busy !== 1'b1 || blink_idx !== 4'd0)) begin
        errors++;
        $display("FAIL held_restart got code=%b busy=%b idx=%0d want 1 1 0", code, busy, blink_idx);
      end
      prev_done = done;
    end
  endtask

  task automatic test_start_abort();
    tick(1'b1, 1'b1);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || code !== 1'b0 || {code, busy, done, blink_idx} !== expected()) begin
      errors++;
      $display("FAIL both_edge got=%b want=%b", {code, busy, done, blink_idx}, expected());
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    vectors++;
    if (busy !== 1'b1 || code !== 1'b1 || blink_idx !== 4'd0) begin
      errors++;
      $display("FAIL both_restart got code=%b busy=%b idx=%0d want 1 1 0", code, busy, blink_idx);
    end
  endtask

  task automatic test_async_reset();
    int busy_n = 0, done_n = 0;
    rst_n = 1'b0;
    model_reset();
    #3;
    release_reset(1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({code, busy, done, blink_idx} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", {code, busy, done, blink_idx}, 7'd0);
    end
    @(posedge clk);
    release_reset(1'b0);
    for (int k = 1; k <= RUN + 2; k++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if ({code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL after_reset k=%0d got=%b want=%b", k, {code, busy, done, blink_idx}, expected());
      end
      busy_n += busy; done_n += done;
    end
    vectors++;
    if (busy_n != RUN || done_n != 1) begin
      errors++;
      $display("FAIL after_reset_totals got busy=%0d done=%0d want %0d 1", busy_n, done_n, RUN);
    end
  endtask

  task automatic test_random();
    logic st, ab;
    for (int k = 0; k < 800; k++) begin
      st = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 39) == 0);
      tick(st, ab);
      vectors++;
      if ({code, busy, done, blink_idx} !== expected()) begin
        errors++;
        $display("FAIL random k=%0d st=%b ab=%b got=%b want=%b", k, st, ab,
                 {code, busy, done, blink_idx}, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_run();
    test_start_rerun();
    test_abort();
    test_start_held();
    test_start_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/startup_blink_sequencer.md
Name: startup_blink_sequencer

Overview:
Power-up self-test sequencer for the selecting machine's display path. It drives the single-bit `code` consumed by the 8x8 lattice decoder and the seven-segment decoder. A code of 1 lights every LED and segment; 0 blanks them. After reset it runs a fixed number of timed on/off blinks, then idles with displays blank and reports completion. It can be re-triggered by a start request and cancelled by an abort.

Parameters:
HALF_PERIOD, 12500000, clock cycles per on-phase and per off-phase (0.25 s at 50 MHz, i.e. a 2 Hz blink); legal range >= 2
BLINK_COUNT, 3, number of on/off pairs per run; legal range 1..15
CNT_W, 24, width of the phase timer; must satisfy 2^CNT_W > HALF_PERIOD

Ports:
clk        input   1      system clock (50 MHz)
rst_n      input   1      asynchronous active-low reset
start      input   1      level, sampled each clk; requests a new run when idle
abort      input   1      level, sampled each clk; cancels a run in progress
code       output  1      display pattern: 1 = all on, 0 = all off (registered)
busy       output  1      1 while a run is in progress (registered)
done       output  1      one-cycle pulse when a run completes normally (registered)
blink_idx  output  4      number of completed on-phases in the current run (registered)

Behaviour:
- Reset (rst_n=0, asynchronous): state=ARM, code=0, busy=0, done=0, blink_idx=0, timer=0. All outputs are held while rst_n=0.
- States: ARM, ON, OFF, IDLE. All outputs come from flops; no combinational path from inputs to outputs.
- ARM: on the first clk edge after rst_n deasserts, go to ON with code=1, busy=1, timer=0. This run is automatic and needs no start.
- ON:
  - timer increments each cycle.
  - On the edge where timer==HALF_PERIOD-1: go to OFF with code=0, timer=0, blink_idx+=1.
  - Result: code is high for exactly HALF_PERIOD cycles.
- OFF:
  - timer increments each cycle.
  - On the edge where timer==HALF_PERIOD-1 and blink_idx==BLINK_COUNT: go to IDLE with busy=0 and done=1 for that single cycle. code stays 0 and blink_idx holds.
  - On the edge where timer==HALF_PERIOD-1 and blink_idx<BLINK_COUNT: go to ON with code=1, timer=0.
- Run length: busy is high for exactly 2*HALF_PERIOD*BLINK_COUNT cycles.
- IDLE:
  - code=0, busy=0, and the timer is frozen at 0.
  - start=1 on an edge: go to ON with code=1, busy=1, blink_idx=0, timer=0. done is cleared the same edge.
- abort:
  - abort=1 in ARM, ON or OFF: go to IDLE next edge with code=0, busy=0, timer=0, no done pulse. blink_idx holds its last value.
  - abort in IDLE: no effect.
- start while in ARM, ON or OFF: ignored; the run is not restarted.
- start and abort on the same edge: abort wins in ARM/ON/OFF. In IDLE, start wins because abort has no effect there.
- done is asserted only on the OFF->IDLE completion edge. It is never asserted by abort or by reset.
- The timer must not wrap. It is cleared on every phase change.
- Reset asserted mid-run: immediate return to the reset values. After release the automatic run restarts from ARM.

Test Plan (HALF_PERIOD=4, BLINK_COUNT=3, CNT_W=3):
1. Release rst_n, start=abort=0 -> one edge later code=1 and busy=1. code then follows the pattern 1111 0000 repeated 3 times (24 cycles). busy falls on the same edge that done pulses high for 1 cycle, and blink_idx=3.
2. In IDLE, pulse start=1 for 1 cycle -> code=1 next edge, blink_idx=0, and a second identical 24-cycle run ends with done=1.
3. During the 2nd on-phase (blink_idx=1), assert abort for 1 cycle -> next edge code=0, busy=0, blink_idx stays 1, and done stays 0 through the following 30 cycles.
4. Hold start=1 continuously from reset release -> the automatic run is not restarted mid-way (pattern identical to test 1). After done, a new run begins on the very next edge.
5. Assert start=1 and abort=1 together mid-run -> IDLE with no done pulse. Then start alone in IDLE -> new run begins.
6. Drop rst_n asynchronously at cycle 10 of a run (between clk edges) -> code, busy, done and blink_idx go to 0 immediately, without waiting for a clk edge. After release, the full 24-cycle run of test 1 repeats exactly.
